// File: rtl/pvt_sensor_pkg.sv
// pvt_sensor_pkg: shared types, constants and frame helpers for pvt_sensor_wrapper.
// Optional build macro: PVT_SENSOR_PARITY_EN adds one even-parity bit between
// data bit 0 and the stop bit of every frame, in both directions.
package pvt_sensor_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'd0,
    CMD_DATA  = 3'd1,
    CMD_READ  = 3'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_PAR  = 2'd2,
    R_STOP = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    C_HDR   = 2'd0,
    C_WDATA = 2'd1,
    C_TX    = 2'd2
  } cmd_state_e;

  localparam int NUM_SLOTS = 4;
  localparam int EN_BIT    = 5;

`ifdef PVT_SENSOR_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Full serial frame, leftmost bit goes out first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
`ifdef PVT_SENSOR_PARITY_EN
    return {1'b0, d, even_parity(d), 1'b1};
`else
    return {1'b0, d, 1'b1};
`endif
  endfunction

endpackage

// File: rtl/pvt_sensor_wrapper_if.sv
// pvt_sensor_wrapper_if: serial link between a host and pvt_sensor_wrapper.
//   rx : host -> wrapper serial commands, idle high
//   tx : wrapper -> host serial responses, idle high
// slave modport is the wrapper side, master modport is the host side.
interface pvt_sensor_wrapper_if;
  logic rx;
  logic tx;

  modport slave  (input rx, output tx);
  modport master (output rx, input tx);
endinterface

// File: rtl/pvt_sensor_slot.sv
// pvt_sensor_slot: behavioural sensor slot, an enable plus a saturating counter.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   en     : slot enable; low holds result at zero
//   result : 8-bit measurement, +1 every 2^TYPE enabled cycles, saturates at 8'hFF
module pvt_sensor_slot #(
  parameter int TYPE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] result
);

  // Prescale terminal count: 0, 1 or 3 for TYPE 0, 1, 2.
  localparam logic [1:0] PRE_MAX = 2'((32'd1 << TYPE) - 32'd1);

  logic [1:0] pre_r;
  logic [7:0] result_r;

  // Prescaler and saturating count; disabling clears both on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r    <= 2'd0;
      result_r <= 8'd0;
    end else if (!en) begin
      pre_r    <= 2'd0;
      result_r <= 8'd0;
    end else if (pre_r == PRE_MAX) begin
      pre_r <= 2'd0;
      if (result_r != 8'hFF) begin
        result_r <= result_r + 8'd1;
      end else begin
        result_r <= result_r;
      end
    end else begin
      pre_r    <= pre_r + 2'd1;
      result_r <= result_r;
    end
  end

  assign result = result_r;

endmodule

// File: rtl/pvt_sensor_wrapper.sv
// pvt_sensor_wrapper: one-bit-per-clock UART front end to four sensor slots.
//   clk   : system clock, one serial bit per cycle
//   rst_n : asynchronous active-low reset
//   bus   : pvt_sensor_wrapper_if.slave (rx commands in, tx responses out)
// Commands are {type[2:0], addr[4:0]}; addr[4:2] must equal GROUP_NO.
// Optional build macro: PVT_SENSOR_PARITY_EN (even parity bit in every frame).
module pvt_sensor_wrapper
  import pvt_sensor_pkg::*;
#(
  parameter int         TYPE     = 0,
  parameter logic [2:0] GROUP_NO = 3'd0
) (
  input logic                  clk,
  input logic                  rst_n,
  pvt_sensor_wrapper_if.slave  bus
);

  // ---------------- UART receiver ----------------
  rx_state_e  rx_state_r, rx_state_s;
  logic [2:0] rx_cnt_r, rx_cnt_s;
  logic [7:0] rx_shift_r, rx_shift_s;
  logic [7:0] rx_byte_r, rx_byte_s;
  logic       rx_valid_r, rx_valid_s;
  logic       rx_err_r, rx_err_s;

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= R_IDLE;
      rx_cnt_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_shift_r <= rx_shift_s;
      rx_byte_r  <= rx_byte_s;
      rx_valid_r <= rx_valid_s;
      rx_err_r   <= rx_err_s;
    end
  end

  // Receiver next state: start, 8 data bits MSB first, optional parity, stop.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_shift_s = rx_shift_r;
    rx_byte_s  = rx_byte_r;
    rx_valid_s = 1'b0;
    rx_err_s   = 1'b0;
    case (rx_state_r)
      R_IDLE: begin
        if (!bus.rx) begin
          rx_state_s = R_DATA;
          rx_cnt_s   = 3'd0;
        end else begin
          rx_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        rx_shift_s = {rx_shift_r[6:0], bus.rx};
        rx_cnt_s   = rx_cnt_r + 3'd1;
        if (rx_cnt_r == 3'd7) begin
`ifdef PVT_SENSOR_PARITY_EN
          rx_state_s = R_PAR;
`else
          rx_state_s = R_STOP;
`endif
        end else begin
          rx_state_s = R_DATA;
        end
      end
      R_PAR: begin
        // A parity mismatch drops the byte just like a bad stop bit.
        if (bus.rx == even_parity(rx_shift_r)) begin
          rx_state_s = R_STOP;
        end else begin
          rx_state_s = R_IDLE;
          rx_err_s   = 1'b1;
        end
      end
      R_STOP: begin
        rx_state_s = R_IDLE;
        if (bus.rx) begin
          rx_valid_s = 1'b1;
          rx_byte_s  = rx_shift_r;
        end else begin
          rx_err_s = 1'b1;
        end
      end
      default: begin
        rx_state_s = R_IDLE;
      end
    endcase
  end

  // ---------------- Command decoder and transmitter ----------------
  cmd_state_e           cmd_state_r, cmd_state_s;
  logic [1:0]           slot_r, slot_s;
  logic [NUM_SLOTS-1:0] en_r, en_s;
  logic [FRAME_BITS-1:0] tx_frame_r, tx_frame_s;
  logic [3:0]           tx_cnt_r, tx_cnt_s;
  logic                 tx_r, tx_s;
  logic [7:0]           result_s [NUM_SLOTS];
  logic                 group_hit_s;

  assign group_hit_s = (rx_byte_r[4:2] == GROUP_NO);

  // Command/transmit state register; tx is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_state_r <= C_HDR;
      slot_r      <= 2'd0;
      en_r        <= '0;
      tx_frame_r  <= '1;
      tx_cnt_r    <= 4'd0;
      tx_r        <= 1'b1;
    end else begin
      cmd_state_r <= cmd_state_s;
      slot_r      <= slot_s;
      en_r        <= en_s;
      tx_frame_r  <= tx_frame_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_r        <= tx_s;
    end
  end

  // Command next state. A READ latches the frame one edge after byte_valid and
  // the start bit leaves on the following edge.
  always_comb begin
    cmd_state_s = cmd_state_r;
    slot_s      = slot_r;
    en_s        = en_r;
    tx_frame_s  = tx_frame_r;
    tx_cnt_s    = tx_cnt_r;
    tx_s        = 1'b1;
    case (cmd_state_r)
      C_HDR: begin
        if (rx_valid_r && group_hit_s) begin
          slot_s = rx_byte_r[1:0];
          if (rx_byte_r[7:5] == CMD_WRITE) begin
            cmd_state_s = C_WDATA;
          end else if (rx_byte_r[7:5] == CMD_READ) begin
            tx_frame_s  = build_frame(result_s[rx_byte_r[1:0]]);
            tx_cnt_s    = 4'd0;
            cmd_state_s = C_TX;
          end else begin
            cmd_state_s = C_HDR;
          end
        end else begin
          cmd_state_s = C_HDR;
        end
      end
      C_WDATA: begin
        if (rx_valid_r) begin
          en_s[slot_r] = rx_byte_r[EN_BIT];
          cmd_state_s  = C_HDR;
        end else if (rx_err_r) begin
          cmd_state_s = C_HDR;
        end else begin
          cmd_state_s = C_WDATA;
        end
      end
      C_TX: begin
        // Incoming bytes are ignored here; leave once the stop bit has had its cycle.
        if (tx_cnt_r == FRAME_LAST) begin
          cmd_state_s = C_HDR;
        end else begin
          tx_s       = tx_frame_r[FRAME_BITS-1];
          tx_frame_s = {tx_frame_r[FRAME_BITS-2:0], 1'b1};
          tx_cnt_s   = tx_cnt_r + 4'd1;
        end
      end
      default: begin
        cmd_state_s = C_HDR;
      end
    endcase
  end

  assign bus.tx = tx_r;

  // ---------------- Sensor slots ----------------
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    pvt_sensor_slot #(.TYPE(TYPE)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_r[i]),
      .result (result_s[i])
    );
  end

endmodule

// File: tb/tb_pvt_sensor_wrapper.sv
// tb_pvt_sensor_wrapper: self-checking bench for pvt_sensor_wrapper (TYPE=0, GROUP_NO=0).
// Expected READ replies are queued when the READ is sent and checked when the
// reply frame arrives. Honors PVT_SENSOR_PARITY_EN for frame layout.
module tb_pvt_sensor_wrapper;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  pvt_sensor_wrapper_if bus_if ();

  pvt_sensor_wrapper #(.TYPE(0), .GROUP_NO(3'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial byte to the DUT; rx changes on negedges, DUT samples on posedges.
  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    @(negedge clk);
    bus_if.rx = 1'b0;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      bus_if.rx = b[i];
      @(negedge clk);
    end
`ifdef PVT_SENSOR_PARITY_EN
    bus_if.rx = ^b;
    @(negedge clk);
`endif
    bus_if.rx = good_stop;
    @(negedge clk);
    bus_if.rx = 1'b1;
  endtask

  // Receive one reply frame and check it against the oldest queued expectation.
  task automatic recv_reply(input string nm);
    exp_t       e;
    int         lat;
    logic [7:0] got;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e   = sb_q.pop_front();
    lat = 0;
    while (bus_if.tx !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (bus_if.tx !== 1'b0) begin
      n_err++;
      $display("FAIL %s_start: no start bit within %0d cycles", nm, lat);
      return;
    end
    // Start bit is launched on the 2nd posedge after the stop bit is sampled.
    n_cmp++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles, expected 2", nm, lat);
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = bus_if.tx;
    end
`ifdef PVT_SENSOR_PARITY_EN
    @(negedge clk);
    n_cmp++;
    if (bus_if.tx !== ^got) begin
      n_err++;
      $display("FAIL %s_parity: got %b expected %b", nm, bus_if.tx, ^got);
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (bus_if.tx !== 1'b1) begin
      n_err++;
      $display("FAIL %s_stop: got %b expected 1", nm, bus_if.tx);
    end
    n_cmp++;
    if ($isunknown(got) || got < e.lo || got > e.hi) begin
      n_err++;
      $display("FAIL %s_data: got %h expected %h..%h", nm, got, e.lo, e.hi);
    end
  endtask

  task automatic read_slot(input logic [7:0] hdr, input logic [7:0] lo,
                           input logic [7:0] hi, input string nm);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    sb_q.push_back(e);
    send_byte(hdr, 1'b1);
    recv_reply(nm);
  endtask

  // tx must stay idle high for the whole window.
  task automatic check_idle(input int cycles, input string nm);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus_if.tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows !== 0) begin
      n_err++;
      $display("FAIL %s: tx not idle on %0d cycles, expected 0", nm, lows);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus_if.rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.tx !== 1'b1) begin
        n_err++;
        $display("FAIL reset_tx: cycle %0d got %b expected 1", i, bus_if.tx);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_slot(8'h40, 8'h00, 8'h00, "reset_read");
  endtask

  task automatic test_enable();
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (20) @(negedge clk);
    read_slot(8'h40, 8'h01, 8'h20, "enable_read");
  endtask

  task automatic test_disable();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    read_slot(8'h40, 8'h00, 8'h00, "disable_read");
  endtask

  task automatic test_group_mismatch();
    send_byte(8'h04, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h44, 1'b1);
    check_idle(30, "group_idle");
    read_slot(8'h40, 8'h00, 8'h00, "group_slot0");
  endtask

  task automatic test_framing();
    send_byte(8'h40, 1'b0);
    check_idle(30, "frame_hdr_idle");
    read_slot(8'h40, 8'h00, 8'h00, "frame_recover");
    // A bad payload frame aborts the write, so slot 0 must stay disabled.
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b0);
    repeat (20) @(negedge clk);
    read_slot(8'h40, 8'h00, 8'h00, "frame_wdata_abort");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.lo = 8'h00;
    e.hi = 8'h00;
    sb_q.push_back(e);
    send_byte(8'h40, 1'b1);
    // The second READ completes while the first reply is still on the wire.
    fork
      send_byte(8'h43, 1'b1);
      recv_reply("b2b_first");
    join
    check_idle(30, "b2b_discard");
  endtask

  task automatic test_saturation();
    int lat;
    send_byte(8'h03, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (300) @(negedge clk);
    read_slot(8'h43, 8'hFF, 8'hFF, "sat_read");
    repeat (3) @(negedge clk);
    send_byte(8'h43, 1'b1);
    lat = 0;
    while (bus_if.tx !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (bus_if.tx !== 1'b0) begin
      n_err++;
      $display("FAIL sat_second_start: got %b expected 0", bus_if.tx);
    end
    // Reset lands mid-reply (during the start bit) and must force tx high at once.
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.tx !== 1'b1) begin
      n_err++;
      $display("FAIL sat_async_reset: got %b expected 1", bus_if.tx);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_slot(8'h43, 8'h00, 8'h00, "sat_after_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.rx = 1'b1;
    test_reset();
    test_enable();
    test_disable();
    test_group_mismatch();
    test_framing();
    test_back_to_back();
    test_saturation();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
